// File: rtl/nios_sys_pio_button_input.sv
// nios_sys_pio_button_input
// Avalon-MM input PIO slave. Pins are synchronized, optionally debounced,
// and selected edges are latched into an edge-capture register that drives
// a level interrupt through a software-programmed mask.
// Build option: define NIOS_SYS_PIO_BUTTON_INPUT_DEBOUNCE_EN to add per-bit
// debounce counters; without it, DEBOUNCE_CYCLES is ignored.
module nios_sys_pio_button_input #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 2,
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s1_p0;
  logic [WIDTH-1:0] s2_p1;
  logic [WIDTH-1:0] stable_p2;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] new_edges;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Bits whose stable-value transition matches the configured edge type.
  function automatic logic [WIDTH-1:0] edge_sel(input logic [WIDTH-1:0] prev,
                                                 input logic [WIDTH-1:0] nxt);
    if (EDGE_TYPE == 0)      edge_sel = ~prev & nxt;
    else if (EDGE_TYPE == 1) edge_sel = prev & ~nxt;
    else                     edge_sel = prev ^ nxt;
  endfunction

  // Armed once three clocks have elapsed since reset release, so pins that
  // are already active at reset load silently instead of capturing an edge.
  assign armed        = (arm_cnt == 2'd3);
  assign wr_en        = chipselect && !write_n;
  assign rd_en        = chipselect && write_n;
  assign unused_wdata = ^writedata;

  // Arm counter: counts up after reset release and saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      arm_cnt <= 2'd0;
    else if (!armed)   arm_cnt <= arm_cnt + 2'd1;
  end

  // Stage p0/p1: two-flop synchronizer on the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_p0 <= '0;
      s2_p1 <= '0;
    end else begin
      s1_p0 <= in_port;
      s2_p1 <= s1_p0;
    end
  end

`ifdef NIOS_SYS_PIO_BUTTON_INPUT_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt     [WIDTH];
  logic [CNT_W-1:0] db_cnt_nxt [WIDTH];

  // A bit is accepted after it has disagreed with stable for DEBOUNCE_CYCLES
  // consecutive cycles; any agreement restarts the count.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      db_cnt_nxt[i] = '0;
      if (!armed) begin
        upd[i] = 1'b1;
      end else if (s2_p1[i] != stable_p2[i]) begin
        if (db_cnt[i] == CNT_LAST) upd[i] = 1'b1;
        else                       db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= db_cnt_nxt[i];
    end
  end
`else
  logic unused_cfg;

  // Without debounce every synchronized sample is accepted immediately.
  assign upd        = '1;
  assign unused_cfg = (DEBOUNCE_CYCLES < 1);
`endif

  // Next stable value, edges to capture, and software clear mask.
  always_comb begin
    stable_nxt = (stable_p2 & ~upd) | (s2_p1 & upd);
    new_edges  = armed ? edge_sel(stable_p2, stable_nxt) : '0;
    clr_mask   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  end

  // Stage p2: accepted pin state and the edge-capture register. A new edge
  // wins over a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_p2   <= '0;
      edgecapture <= '0;
    end else begin
      stable_p2   <= stable_nxt;
      edgecapture <= (edgecapture & ~clr_mask) | new_edges;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        irqmask <= '0;
    else if (wr_en && address == 2'd2)   irqmask <= writedata[WIDTH-1:0];
  end

  // Read mux; unused high bits and the reserved address read as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable_p2;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, loaded only on a read strobe and held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    readdata <= '0;
    else if (rd_en)  readdata <= rd_mux;
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios_sys_pio_button_input.sv
// Bench for nios_sys_pio_button_input: three instances (rising, falling,
// any edge) share the bus and pins and are compared against a cycle model.
`timescale 1ns/1ps
module tb_nios_sys_pio_button_input;

  localparam int W  = 8;
  localparam int DB = 4;
`ifdef NIOS_SYS_PIO_BUTTON_INPUT_DEBOUNCE_EN
  localparam int ACCEPT = DB;
`else
  localparam int ACCEPT = 1;
`endif
  // Sample edge to capture edge, and a settle time long enough for any change.
  localparam int LAT  = ACCEPT + 1;
  localparam int WAIT = ACCEPT + 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      address;
  logic            chipselect;
  logic            write_n;
  logic [31:0]     writedata;
  logic [W-1:0]    in_port;
  logic [2:0][31:0] rd_w;
  logic [2:0]      irq_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nios_sys_pio_button_input #(
      .WIDTH(W), .EDGE_TYPE(g), .DEBOUNCE_CYCLES(DB)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_w[g]),
      .in_port(in_port), .irq(irq_w[g])
    );
  end

  // Reference model: pins pass a 2-cycle delay line; a delayed pin value is
  // accepted once it has disagreed with the accepted value for ACCEPT
  // consecutive cycles; nothing is captured until 3 clocks after reset.
  logic [W-1:0] m_d1, m_d2, m_stable, m_nstable, m_mask, m_clr, m_rise, m_fall;
  logic [W-1:0] m_ec [3];
  logic [31:0]  m_rd [3];
  int           m_run [W];
  int           m_since;
  logic         m_armed;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0; m_mask = '0; m_since = 0;
      for (int i = 0; i < 3; i++) begin m_ec[i] = '0; m_rd[i] = '0; end
      for (int b = 0; b < W; b++) m_run[b] = 0;
    end else begin
      m_armed   = (m_since >= 3);
      m_nstable = m_stable;
      for (int b = 0; b < W; b++) begin
        if (!m_armed) begin
          m_nstable[b] = m_d2[b];
          m_run[b] = 0;
        end else if (m_d2[b] == m_stable[b]) begin
          m_run[b] = 0;
        end else begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] >= ACCEPT) begin
            m_nstable[b] = m_d2[b];
            m_run[b] = 0;
          end
        end
      end
      m_rise = m_armed ? (~m_stable & m_nstable) : '0;
      m_fall = m_armed ? (m_stable & ~m_nstable) : '0;
      m_clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      if (chipselect && write_n) begin
        for (int i = 0; i < 3; i++) begin
          case (address)
            2'd0:    m_rd[i] = {24'h0, m_stable};
            2'd2:    m_rd[i] = {24'h0, m_mask};
            2'd3:    m_rd[i] = {24'h0, m_ec[i]};
            default: m_rd[i] = 32'h0;
          endcase
        end
      end
      m_ec[0] = (m_ec[0] & ~m_clr) | m_rise;
      m_ec[1] = (m_ec[1] & ~m_clr) | m_fall;
      m_ec[2] = (m_ec[2] & ~m_clr) | m_rise | m_fall;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_stable = m_nstable;
      m_d2 = m_d1;
      m_d1 = in_port;
      if (m_since < 3) m_since++;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_port = 8'hFF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'h0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_w[i] !== 32'h0 || irq_w[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state inst%0d: readdata=%h irq=%b, required 0 and 0", i, rd_w[i], irq_w[i]);
      end
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    bus_read(2'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_w[i] !== 32'hFF || rd_w[i] !== m_rd[i]) begin
        n_err++;
        $display("FAIL armed_data inst%0d: got %h, required 000000ff (model %h)", i, rd_w[i], m_rd[i]);
      end
    end
    bus_read(2'd3);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_w[i] !== 32'h0 || irq_w[i] !== 1'b0) begin
        n_err++;
        $display("FAIL armed_edgecapture inst%0d: got %h irq=%b, required 0 and 0", i, rd_w[i], irq_w[i]);
      end
    end
  endtask

  task automatic test_rise_clear();
    logic exp;
    in_port = 8'h00;
    repeat (WAIT) @(negedge clk);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h01);
    in_port = 8'h01;
    for (int k = 1; k <= WAIT; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        exp = (i != 1) && (k - 1 >= LAT);
        n_vec++;
        if (irq_w[i] !== exp || irq_w[i] !== (|(m_ec[i] & m_mask))) begin
          n_err++;
          $display("FAIL rise_latency inst%0d cycle%0d: irq=%b, required %b", i, k, irq_w[i], exp);
        end
      end
    end
    bus_read(2'd3);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_w[i] !== ((i == 1) ? 32'h0 : 32'h1) || rd_w[i] !== m_rd[i]) begin
        n_err++;
        $display("FAIL rise_capture inst%0d: edgecapture=%h, required %h", i, rd_w[i], (i == 1) ? 32'h0 : 32'h1);
      end
    end
    bus_write(2'd3, 32'h01);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (irq_w[i] !== 1'b0) begin
        n_err++;
        $display("FAIL clear_irq inst%0d: irq=%b, required 0", i, irq_w[i]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] exp0;
    in_port[3] = 1'b1;
    repeat (3) @(negedge clk);
    in_port[3] = 1'b0;
    repeat (WAIT) @(negedge clk);
    bus_read(2'd0);
    n_vec++;
    if (rd_w[0] !== 32'h01 || rd_w[0] !== m_rd[0]) begin
      n_err++;
      $display("FAIL glitch_data: data=%h, required 00000001", rd_w[0]);
    end
    bus_read(2'd3);
    exp0 = (ACCEPT > 3) ? 32'h0 : 32'h08;
    n_vec++;
    if (rd_w[0] !== exp0 || rd_w[0] !== m_rd[0]) begin
      n_err++;
      $display("FAIL glitch_capture: edgecapture=%h, required %h", rd_w[0], exp0);
    end
    bus_write(2'd3, 32'hFF);
    in_port[3] = 1'b1;
    repeat (WAIT) @(negedge clk);
    bus_read(2'd3);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_w[i] !== ((i == 1) ? 32'h0 : 32'h08) || rd_w[i] !== m_rd[i]) begin
        n_err++;
        $display("FAIL hold_capture inst%0d: edgecapture=%h, required %h", i, rd_w[i], (i == 1) ? 32'h0 : 32'h08);
      end
    end
  endtask

  task automatic test_falling();
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'hFF);
    in_port[5] = 1'b1;
    repeat (WAIT) @(negedge clk);
    in_port[5] = 1'b0;
    repeat (WAIT) @(negedge clk);
    bus_read(2'd3);
    n_vec++;
    if (rd_w[1] !== 32'h20 || irq_w[1] !== 1'b0 || rd_w[1] !== m_rd[1]) begin
      n_err++;
      $display("FAIL falling_capture: edgecapture=%h irq=%b, required 00000020 and 0", rd_w[1], irq_w[1]);
    end
    bus_write(2'd2, 32'h20);
    n_vec++;
    if (irq_w[1] !== 1'b1) begin
      n_err++;
      $display("FAIL mask_irq: irq=%b, required 1", irq_w[1]);
    end
  endtask

  task automatic test_set_wins();
    bus_write(2'd3, 32'hFF);
    in_port[2] = 1'b1;
    repeat (LAT) @(negedge clk);
    bus_write(2'd3, 32'h04);
    bus_read(2'd3);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_w[i] !== ((i == 1) ? 32'h0 : 32'h04) || rd_w[i] !== m_rd[i]) begin
        n_err++;
        $display("FAIL set_wins inst%0d: edgecapture=%h, required %h", i, rd_w[i], (i == 1) ? 32'h0 : 32'h04);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'hFF);
    in_port = in_port ^ 8'h81;
    repeat (WAIT) @(negedge clk);
    bus_read(2'd3);
    n_vec++;
    if (rd_w[2] !== 32'h81 || irq_w[2] !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_capture: edgecapture=%h irq=%b, required 00000081 and 1", rd_w[2], irq_w[2]);
    end
    in_port[1] = ~in_port[1];
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_w[i] !== 32'h0 || irq_w[i] !== 1'b0) begin
        n_err++;
        $display("FAIL async_reset inst%0d: readdata=%h irq=%b, required 0 and 0", i, rd_w[i], irq_w[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (WAIT) @(negedge clk);
    bus_read(2'd3);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_w[i] !== 32'h0 || irq_w[i] !== 1'b0) begin
        n_err++;
        $display("FAIL rearm_capture inst%0d: edgecapture=%h irq=%b, required 0 and 0", i, rd_w[i], irq_w[i]);
      end
    end
    bus_read(2'd0);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (rd_w[i] !== {24'h0, in_port}) begin
        n_err++;
        $display("FAIL rearm_data inst%0d: data=%h, required %h", i, rd_w[i], {24'h0, in_port});
      end
    end
    bus_read(2'd2);
    n_vec++;
    if (rd_w[0] !== 32'h0) begin
      n_err++;
      $display("FAIL rearm_mask: irqmask=%h, required 0", rd_w[0]);
    end
  endtask

  task automatic test_random();
    int r;
    int b;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (irq_w[i] !== (|(m_ec[i] & m_mask)) || rd_w[i] !== m_rd[i]) begin
          n_err++;
          $display("FAIL random c%0d inst%0d: readdata=%h irq=%b, required %h and %b",
                   c, i, rd_w[i], irq_w[i], m_rd[i], |(m_ec[i] & m_mask));
        end
      end
      r = int'($urandom_range(0, 9));
      chipselect = 1'b0; write_n = 1'b1;
      if (r < 3) begin
        chipselect = 1'b1; address = 2'($urandom_range(0, 3));
      end else if (r < 5) begin
        chipselect = 1'b1; write_n = 1'b0;
        address = 2'($urandom_range(0, 3)); writedata = $urandom();
      end else if (r == 5) begin
        write_n = 1'b0; address = 2'd3; writedata = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 5) == 0) begin
        b = int'($urandom_range(0, W - 1));
        in_port[b] = ~in_port[b];
      end
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rise_clear();
    test_glitch();
    test_falling();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
